// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares a single-port frame-buffer SRAM between the display fetch path
//   (reads, priority) and the draw path (writes). It sequences each SRAM
//   access (address setup, OE/WE strobes, data capture) and bounds the number
//   of back-to-back fetch grants while a draw is waiting.
//
// Ports
//   Clk, Reset        clock, synchronous active-high reset
//   fetch_req/addr    display read request and address (held until fetch_gnt)
//   fetch_gnt         one-cycle pulse, read accepted
//   fetch_valid       one-cycle pulse, fetch_rdata holds the read word
//   fetch_rdata       read data, holds between valid pulses
//   draw_req/addr/wdata  draw write request, address, data (held until draw_gnt)
//   draw_gnt          one-cycle pulse, write accepted
//   draw_done         one-cycle pulse, write cycle complete
//   SRAM_ADDR         registered SRAM word address
//   SRAM_OE_N/WE_N    active-low output / write enables
//   SRAM_DQ_OUT/OE    write data toward the pad and its drive enable
//   SRAM_DQ_IN        pad data from the SRAM
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int MAX_FETCH_RUN = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_gnt,
    output logic              draw_done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [DATA_W-1:0] SRAM_DQ_OUT,
    output logic              SRAM_DQ_OE,
    input  logic [DATA_W-1:0] SRAM_DQ_IN
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_LATCH,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          run_cnt_q, run_cnt_d;
    logic                fetch_gnt_q, fetch_gnt_d;
    logic                draw_gnt_q, draw_gnt_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                draw_done_q, draw_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_out_q, dq_out_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;

    logic                decide;
    logic                pick_fetch;
    logic                pick_draw;

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        addr_d        = addr_q;
        dq_out_d      = dq_out_q;
        rdata_d       = rdata_q;
        fetch_gnt_d   = 1'b0;
        draw_gnt_d    = 1'b0;
        fetch_valid_d = 1'b0;
        draw_done_d   = 1'b0;

        // Grants are registered, so arbitration is evaluated on the edge that
        // enters an IDLE cycle: from RD_LATCH, WR_HOLD, or an IDLE cycle that
        // did not already carry a grant. The grant then shows in that IDLE
        // cycle and the following edge launches the access.
        decide = (state_q == RD_LATCH) || (state_q == WR_HOLD) ||
                 ((state_q == IDLE) && !fetch_gnt_q && !draw_gnt_q);

        pick_fetch = decide && fetch_req &&
                     (!draw_req || (run_cnt_q < 4'(MAX_FETCH_RUN)));
        pick_draw  = decide && draw_req && !pick_fetch;

        case (state_q)
            IDLE: begin
                if (fetch_gnt_q)
                    state_d = RD_SETUP;
                else if (draw_gnt_q)
                    state_d = WR_SETUP;
            end
            RD_SETUP: state_d = RD_LATCH;
            RD_LATCH: state_d = IDLE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        fetch_gnt_d = pick_fetch;
        draw_gnt_d  = pick_draw;

        if (pick_fetch)
            addr_d = fetch_addr;
        else if (pick_draw)
            addr_d = draw_addr;

        if (pick_draw)
            dq_out_d = draw_wdata;

        if (pick_draw || (decide && !draw_req) || ((state_q == IDLE) && !draw_req))
            run_cnt_d = '0;
        else if (pick_fetch && (run_cnt_q < 4'(MAX_FETCH_RUN)))
            run_cnt_d = run_cnt_q + 4'd1;

        if (state_q == RD_LATCH) begin
            rdata_d       = SRAM_DQ_IN;
            fetch_valid_d = 1'b1;
        end

        // Strobes are registered from the next state so they line up with
        // the state they belong to.
        oe_n_d      = !((state_d == RD_SETUP) || (state_d == RD_LATCH));
        we_n_d      = !(state_d == WR_PULSE);
        dq_oe_d     = (state_d == WR_SETUP) || (state_d == WR_PULSE) ||
                      (state_d == WR_HOLD);
        draw_done_d = (state_d == WR_HOLD);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            run_cnt_q     <= '0;
            fetch_gnt_q   <= 1'b0;
            draw_gnt_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            draw_done_q   <= 1'b0;
            rdata_q       <= '0;
            addr_q        <= '0;
            dq_out_q      <= '0;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            dq_oe_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            fetch_gnt_q   <= fetch_gnt_d;
            draw_gnt_q    <= draw_gnt_d;
            fetch_valid_q <= fetch_valid_d;
            draw_done_q   <= draw_done_d;
            rdata_q       <= rdata_d;
            addr_q        <= addr_d;
            dq_out_q      <= dq_out_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            dq_oe_q       <= dq_oe_d;
        end
    end

    assign fetch_gnt   = fetch_gnt_q;
    assign draw_gnt    = draw_gnt_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_rdata = rdata_q;
    assign draw_done   = draw_done_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_DQ_OUT = dq_out_q;
    assign SRAM_DQ_OE  = dq_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          Clk;
    logic          Reset;

    // main DUT (MAX_FETCH_RUN = 4)
    logic          fetch_req, fetch_gnt, fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_rdata;
    logic          draw_req, draw_gnt, draw_done;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_wdata;
    logic [AW-1:0] sram_addr;
    logic          oe_n, we_n, dq_oe;
    logic [DW-1:0] dq_out, dq_in;

    // second DUT (MAX_FETCH_RUN = 2)
    logic          f2_req, f2_gnt, f2_valid;
    logic [DW-1:0] f2_rdata;
    logic          d2_req, d2_gnt, d2_done;
    logic [AW-1:0] s2_addr;
    logic          oe2_n, we2_n, dq2_oe;
    logic [DW-1:0] dq2_out;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    int unsigned   cyc     = 0;
    int unsigned   out_fetch = 0;

    byte           exp_gnt[$];
    logic [DW-1:0] exp_rdata[$];
    logic [AW-1:0] exp_done_addr[$];
    logic [DW-1:0] exp_done_data[$];
    byte           exp_gnt2[$];

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_FETCH_RUN(4)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
        .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .draw_gnt(draw_gnt), .draw_done(draw_done),
        .SRAM_ADDR(sram_addr), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_DQ_OUT(dq_out), .SRAM_DQ_OE(dq_oe), .SRAM_DQ_IN(dq_in)
    );

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_FETCH_RUN(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset),
        .fetch_req(f2_req), .fetch_addr(20'h00010), .fetch_gnt(f2_gnt),
        .fetch_valid(f2_valid), .fetch_rdata(f2_rdata),
        .draw_req(d2_req), .draw_addr(20'h00020), .draw_wdata(16'h0F0F),
        .draw_gnt(d2_gnt), .draw_done(d2_done),
        .SRAM_ADDR(s2_addr), .SRAM_OE_N(oe2_n), .SRAM_WE_N(we2_n),
        .SRAM_DQ_OUT(dq2_out), .SRAM_DQ_OE(dq2_oe), .SRAM_DQ_IN(dq2_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // SRAM model: preload port for the bench, write on a clock edge while WE_N is low
    assign dq_in = mem[sram_addr];
    always @(posedge Clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (!we_n)
            mem[sram_addr] <= dq_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard monitor for the main DUT
    always @(negedge Clk) begin
        chk("invariant", {(oe_n | we_n), !(dq_oe && !oe_n)}, 2'b11);
        if (fetch_gnt) begin
            out_fetch++;
            if (exp_gnt.size() == 0) bad("unexpected_fetch_gnt");
            else chk("gnt_order", 32'(byte'("F")), 32'(exp_gnt.pop_front()));
        end
        if (draw_gnt) begin
            if (exp_gnt.size() == 0) bad("unexpected_draw_gnt");
            else chk("gnt_order", 32'(byte'("D")), 32'(exp_gnt.pop_front()));
        end
        if (fetch_valid) begin
            if (out_fetch == 0) bad("fetch_valid_without_gnt");
            else out_fetch--;
            if (exp_rdata.size() == 0) bad("unexpected_fetch_valid");
            else chk("fetch_rdata", 32'(fetch_rdata), 32'(exp_rdata.pop_front()));
        end
        if (draw_done) begin
            if (exp_done_addr.size() == 0) bad("unexpected_draw_done");
            else begin
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                a = exp_done_addr.pop_front();
                d = exp_done_data.pop_front();
                chk("done_addr", 32'(sram_addr), 32'(a));
                chk("mem_written", 32'(mem[a]), 32'(d));
            end
        end
    end

    // Monitor for the MAX_FETCH_RUN = 2 instance
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("invariant2", {(oe2_n | we2_n), !(dq2_oe && !oe2_n)}, 2'b11);
            if (f2_gnt) begin
                if (exp_gnt2.size() == 0) bad("unexpected_fetch_gnt2");
                else chk("gnt_order2", 32'(byte'("F")), 32'(exp_gnt2.pop_front()));
            end
            if (d2_gnt) begin
                if (exp_gnt2.size() == 0) bad("unexpected_draw_gnt2");
                else chk("gnt_order2", 32'(byte'("D")), 32'(exp_gnt2.pop_front()));
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge Clk); #1;
        pre_we   = 1'b0;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        exp_gnt.push_back("F");
        exp_rdata.push_back(d);
        fetch_addr = a;
        fetch_req  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge Clk); #1;
            if (fetch_gnt) begin
                got = 1'b1;
                break;
            end
        end
        fetch_req = 1'b0;
        if (!got) begin
            bad("fetch_gnt_timeout");
            return;
        end
        @(posedge Clk); #1;
        chk("rd_t1_oe_n", 32'(oe_n), 0);
        chk("rd_t1_addr", 32'(sram_addr), 32'(a));
        chk("rd_t1_dq_oe", 32'(dq_oe), 0);
        @(posedge Clk); #1;
        chk("rd_t2_oe_n", 32'(oe_n), 0);
        chk("rd_t2_valid", 32'(fetch_valid), 0);
        @(posedge Clk); #1;
        chk("rd_t3_valid", 32'(fetch_valid), 1);
        chk("rd_t3_oe_n", 32'(oe_n), 1);
    endtask

    task automatic do_draw(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit abort);
        bit got;
        got = 1'b0;
        exp_gnt.push_back("D");
        exp_done_addr.push_back(a);
        exp_done_data.push_back(d);
        draw_addr  = a;
        draw_wdata = d;
        draw_req   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge Clk); #1;
            if (draw_gnt) begin
                got = 1'b1;
                break;
            end
        end
        draw_req = 1'b0;
        if (!got) begin
            bad("draw_gnt_timeout");
            return;
        end
        @(posedge Clk); #1;
        chk("wr_t1_dq_oe", 32'(dq_oe), 1);
        chk("wr_t1_we_n", 32'(we_n), 1);
        chk("wr_t1_oe_n", 32'(oe_n), 1);
        chk("wr_t1_dq_out", 32'(dq_out), 32'(d));
        chk("wr_t1_addr", 32'(sram_addr), 32'(a));
        @(posedge Clk); #1;
        chk("wr_t2_we_n", 32'(we_n), 0);
        chk("wr_t2_dq_oe", 32'(dq_oe), 1);
        if (abort) begin
            // this write will be cut short: its draw_done must never appear
            void'(exp_done_addr.pop_back());
            void'(exp_done_data.pop_back());
            Reset = 1'b1;
            @(posedge Clk); #1;
            chk("rst_we_n", 32'(we_n), 1);
            chk("rst_dq_oe", 32'(dq_oe), 0);
            chk("rst_oe_n", 32'(oe_n), 1);
            chk("rst_done", 32'(draw_done), 0);
            @(posedge Clk); #1;
            Reset = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        chk("wr_t3_we_n", 32'(we_n), 1);
        chk("wr_t3_dq_oe", 32'(dq_oe), 1);
        chk("wr_t3_done", 32'(draw_done), 1);
        @(posedge Clk); #1;
        chk("wr_t4_dq_oe", 32'(dq_oe), 0);
        chk("wr_t4_done", 32'(draw_done), 0);
    endtask

    initial begin
        int unsigned nf, ng;
        int unsigned fc0, fc1;
        bit gotd, fin;

        Reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        draw_req   = 1'b0;
        draw_addr  = '0;
        draw_wdata = '0;
        f2_req     = 1'b0;
        d2_req     = 1'b0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;

        preload(20'h00123, 16'hBEEF);
        preload(20'h0ABCD, 16'h0000);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_oe_n", 32'(oe_n), 1);
        chk("rst_we_n", 32'(we_n), 1);
        chk("rst_dq_oe", 32'(dq_oe), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dq_out", 32'(dq_out), 0);
        chk("rst_rdata", 32'(fetch_rdata), 0);
        chk("rst_pulses", {29'd0, fetch_gnt, fetch_valid, draw_gnt | draw_done}, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // single read and single write
        do_fetch(20'h00123, 16'hBEEF);
        repeat (3) @(posedge Clk);
        #1;
        chk("rdata_hold", 32'(fetch_rdata), 32'hBEEF);
        do_draw(20'h0ABCD, 16'h5A5A, 1'b0);
        do_fetch(20'h0ABCD, 16'h5A5A);

        // priority: both rise together, draw waits for 4 fetch grants
        repeat (2) @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) exp_gnt.push_back("F");
        exp_gnt.push_back("D");
        exp_gnt.push_back("F");
        for (int i = 0; i < 5; i++) exp_rdata.push_back(16'hBEEF);
        exp_done_addr.push_back(20'h00200);
        exp_done_data.push_back(16'h1111);
        fetch_addr = 20'h00123;
        draw_addr  = 20'h00200;
        draw_wdata = 16'h1111;
        fetch_req  = 1'b1;
        draw_req   = 1'b1;
        nf = 0; gotd = 1'b0; fin = 1'b0; fc0 = 0; fc1 = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge Clk); #1;
            if (fetch_gnt) begin
                if (nf == 0) fc0 = cyc;
                if (nf == 1) fc1 = cyc;
                nf++;
                if (nf == 5) fetch_req = 1'b0;
            end
            if (draw_gnt) begin
                chk("fetches_before_draw", nf, 4);
                gotd = 1'b1;
                draw_req = 1'b0;
            end
            if (gotd && nf >= 5) begin
                fin = 1'b1;
                break;
            end
        end
        fetch_req = 1'b0;
        draw_req  = 1'b0;
        if (!fin) bad("priority_timeout");
        chk("fetch_period", fc1 - fc0, 3);
        repeat (6) @(posedge Clk);
        #1;

        // starvation bound on the MAX_FETCH_RUN = 2 instance
        exp_gnt2.push_back("F"); exp_gnt2.push_back("F"); exp_gnt2.push_back("D");
        exp_gnt2.push_back("F"); exp_gnt2.push_back("F"); exp_gnt2.push_back("D");
        f2_req = 1'b1;
        d2_req = 1'b1;
        ng = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge Clk); #1;
            if (f2_gnt || d2_gnt) ng++;
            if (ng == 6) break;
        end
        f2_req = 1'b0;
        d2_req = 1'b0;
        chk("starve_grants", ng, 6);
        repeat (6) @(posedge Clk);
        #1;

        // reset during WR_PULSE, then normal service
        do_draw(20'h00300, 16'h7777, 1'b1);
        do_fetch(20'h00123, 16'hBEEF);
        do_draw(20'h00400, 16'hC3C3, 1'b0);

        repeat (10) @(posedge Clk);
        #1;
        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("rdata_queue_empty", exp_rdata.size(), 0);
        chk("done_queue_empty", exp_done_addr.size(), 0);
        chk("gnt2_queue_empty", exp_gnt2.size(), 0);
        chk("fetch_outstanding", out_fetch, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM arbiter for the frame-buffer memory. It shares the external SRAM between two requesters. The display fetch path reads pixel words and has priority. The draw path writes sprite/background words. The block sequences every SRAM access cycle (address setup, OE/WE strobes, data capture) and enforces a starvation bound so the draw path always makes progress.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- MAX_FETCH_RUN, 4, maximum consecutive fetch grants while draw_req is pending (1..15)

Ports:
- Clk  in  1  system clock; every flop updates on its rising edge
- Reset  in  1  synchronous, active-high
- fetch_req  in  1  display read request; held until fetch_gnt
- fetch_addr  in  ADDR_W  read address; stable while fetch_req is high
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted, address captured
- fetch_valid  out  1  one-cycle pulse: fetch_rdata holds the read word
- fetch_rdata  out  DATA_W  read data; holds its value between valid pulses
- draw_req  in  1  draw write request; held until draw_gnt
- draw_addr  in  ADDR_W  write address; stable while draw_req is high
- draw_wdata  in  DATA_W  write data; stable while draw_req is high
- draw_gnt  out  1  one-cycle pulse: write accepted, address/data captured
- draw_done  out  1  one-cycle pulse: write cycle complete on SRAM
- SRAM_ADDR  out  ADDR_W  registered SRAM address
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_DQ_OUT  out  DATA_W  write data toward the pad
- SRAM_DQ_OE  out  1  1 = drive the DQ pad with SRAM_DQ_OUT
- SRAM_DQ_IN  in  DATA_W  pad data from SRAM

## Operation
- States: IDLE, RD_SETUP, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE arbitration runs every cycle in IDLE:
  - fetch_req only → fetch.
  - draw_req only → draw.
  - Both requests, run_cnt < MAX_FETCH_RUN → fetch.
  - Both requests, run_cnt == MAX_FETCH_RUN → draw.
  - The chosen grant pulses in that IDLE cycle. Address/data are captured into internal registers on the same edge.
- Read path: IDLE → RD_SETUP → RD_LATCH → IDLE.
  - RD_SETUP: SRAM_ADDR = captured address, OE_N = 0.
  - RD_LATCH: OE_N = 0. SRAM_DQ_IN is registered into fetch_rdata at the end of the cycle.
  - fetch_valid pulses in the following IDLE cycle.
- Write path: IDLE → WR_SETUP → WR_PULSE → WR_HOLD → IDLE.
  - DQ_OE = 1 and SRAM_DQ_OUT = captured data in all three write states.
  - WE_N = 0 only in WR_PULSE, giving setup and hold around the WE pulse.
  - OE_N = 1 throughout the write.
  - draw_done pulses in WR_HOLD.
- run_cnt (4 bits):
  - Increments on each fetch grant issued while draw_req = 1, saturating at MAX_FETCH_RUN.
  - Clears on a draw grant, and in any IDLE cycle with draw_req = 0.
- No grant is issued outside IDLE. Requests arriving mid-transaction wait.
- OE_N and WE_N are never low in the same cycle. DQ_OE = 1 never coincides with OE_N = 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: state = IDLE, run_cnt = 0, SRAM_OE_N = 1, SRAM_WE_N = 1, SRAM_DQ_OE = 0, SRAM_ADDR = 0, SRAM_DQ_OUT = 0, fetch_rdata = 0, all gnt/valid/done = 0.
- Read: fetch_gnt at cycle T. SRAM_ADDR valid and OE_N low in T+1 and T+2. fetch_valid at T+3. Next grant possible at T+3.
- Write: draw_gnt at T. WE_N low only in T+2. draw_done at T+3. Next grant possible at T+4.
- Sustained fetch-only throughput: one word per 3 cycles.
- Reset mid-transaction: on the reset edge, OE_N/WE_N return to 1 and DQ_OE to 0. The aborted read produces no fetch_valid; the aborted write produces no draw_done.
- A requester keeping req high after its grant is treated as a new request at the next IDLE.

## Test plan
- Single read: SRAM model returns 0xBEEF at 0x00123; fetch_req with addr 0x00123 → fetch_gnt at T, OE_N low T+1..T+2, fetch_valid at T+3 with rdata 0xBEEF.
- Single write: draw addr 0x0ABCD, data 0x5A5A → draw_gnt T, DQ_OE high T+1..T+3, WE_N low only at T+2, draw_done T+3, model holds 0x5A5A.
- Priority: fetch_req and draw_req rise in the same cycle with run_cnt = 0 → fetch_gnt first. draw_gnt is held off until 4 fetch grants, then issued on the 5th arbitration; after the write, fetch resumes.
- Starvation bound, MAX_FETCH_RUN = 2: both requests held continuously → grant order F,F,D,F,F,D.
- Reset during WR_PULSE: WE_N = 1 and DQ_OE = 0 on the reset edge, no draw_done, state IDLE, next request served normally.
- Invariant checks (assertions, all tests): OE_N and WE_N never both 0; DQ_OE never high while OE_N = 0; exactly one fetch_valid per fetch_gnt absent reset.
